// File: rtl/pe_mac_pkg.sv
// -----------------------------------------------------------------------------
// pe_mac_pkg
// Shared definitions for the PE MAC lane array: default widths, saturation
// bound helpers, the lane-slice index helper and the ReLU helper used by the
// optional rectified read-out.
// -----------------------------------------------------------------------------
package pe_mac_pkg;

    localparam int DEF_NUM_LANES  = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_WIDTH = 8;
    localparam int DEF_ACC_DEPTH  = 64;

    // Largest value representable in a signed field of the given width.
    function automatic logic signed [63:0] sat_max_f(input int width);
        sat_max_f = (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a signed field of the given width.
    function automatic logic signed [63:0] sat_min_f(input int width);
        sat_min_f = -(64'sd1 <<< (width - 1));
    endfunction

    // Low bit index of a lane inside a packed multi-lane bus.
    function automatic int lane_lo_f(input int lane, input int width);
        lane_lo_f = lane * width;
    endfunction

    // Rectify a signed value held in the low 'width' bits: negatives become 0.
    function automatic logic [63:0] relu_f(input logic [63:0] value, input int width);
        if (value[width - 1]) begin
            relu_f = 64'd0;
        end else begin
            relu_f = value;
        end
    endfunction

endpackage

// File: rtl/pe_mac_chk.sv
// -----------------------------------------------------------------------------
// pe_mac_chk
// Address-range checker for the MAC lane array. The datapath has no guard
// against out-of-range addresses when ACC_DEPTH is not a power of two; this
// module flags such accesses in simulation.
// Ports: clk, rst (sync active-low), in_fire (operand accepted), in_addr,
//        rd_en, rd_addr.
// -----------------------------------------------------------------------------
module pe_mac_chk #(
    parameter int ACC_DEPTH  = 64,
    parameter int ADDR_WIDTH = $clog2(ACC_DEPTH)
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  in_fire,
    input logic [ADDR_WIDTH-1:0] in_addr,
    input logic                  rd_en,
    input logic [ADDR_WIDTH-1:0] rd_addr
);

    a_in_addr_range: assert property (@(posedge clk) disable iff (!rst)
        in_fire |-> (32'(in_addr) < ACC_DEPTH));

    a_rd_addr_range: assert property (@(posedge clk) disable iff (!rst)
        rd_en |-> (32'(rd_addr) < ACC_DEPTH));

endmodule

// File: rtl/pe_mac_lane.sv
// -----------------------------------------------------------------------------
// pe_mac_lane
// One MAC lane: S2 product register, S3 shifted-product register, saturating
// accumulate into an ACC_DEPTH-entry register file, sticky overflow flag and a
// combinational read port with write-first bypass from S3.
// Ports: clk, rst (sync active-low), clear, s1/s2/s3_valid (stage valids from
//        the top), act/w (S1 operands), s3_addr (write address),
//        rd_addr/rd_value (read port), ovf (sticky saturation flag).
// -----------------------------------------------------------------------------
module pe_mac_lane
    import pe_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
    parameter int ACC_DEPTH  = DEF_ACC_DEPTH,
    parameter int ADDR_WIDTH = $clog2(ACC_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         s1_valid,
    input  logic                         s2_valid,
    input  logic                         s3_valid,
    input  logic signed [DATA_WIDTH-1:0] act,
    input  logic signed [DATA_WIDTH-1:0] w,
    input  logic        [ADDR_WIDTH-1:0] s3_addr,
    input  logic        [ADDR_WIDTH-1:0] rd_addr,
    output logic        [DATA_WIDTH-1:0] rd_value,
    output logic                         ovf
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    // The sum is formed wide enough that a large shifted product can never
    // wrap before the clamp decision is made.
    localparam int SUM_W  = PROD_W + 1;

    localparam logic signed [SUM_W-1:0]      SUM_MAX = SUM_W'(sat_max_f(DATA_WIDTH));
    localparam logic signed [SUM_W-1:0]      SUM_MIN = SUM_W'(sat_min_f(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] ACC_MAX = DATA_WIDTH'(sat_max_f(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] ACC_MIN = DATA_WIDTH'(sat_min_f(DATA_WIDTH));

    logic signed [PROD_W-1:0]     prod_r;
    logic signed [PROD_W-1:0]     shift_r;
    logic signed [DATA_WIDTH-1:0] acc_r [ACC_DEPTH];
    logic signed [DATA_WIDTH-1:0] acc_cur_s;
    logic signed [DATA_WIDTH-1:0] acc_new_s;
    logic signed [SUM_W-1:0]      sum_s;
    logic                         sat_s;
    logic                         ovf_r;

    // S2: full-width signed product of the S1 operands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_r <= '0;
        end else if (s1_valid) begin
            prod_r <= PROD_W'(act) * PROD_W'(w);
        end
    end

    // S3: rescale the product; arithmetic shift truncates toward -inf.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_r <= '0;
        end else if (s2_valid) begin
            shift_r <= prod_r >>> FRAC_WIDTH;
        end
    end

    // S3 accumulate: read-modify-write against the array; the previous op to
    // the same address was written one edge earlier, so no forwarding needed.
    always_comb begin
        acc_cur_s = acc_r[s3_addr];
        sum_s     = SUM_W'(shift_r) + SUM_W'(acc_cur_s);
        acc_new_s = sum_s[DATA_WIDTH-1:0];
        sat_s     = 1'b0;
        if (sum_s > SUM_MAX) begin
            acc_new_s = ACC_MAX;
            sat_s     = 1'b1;
        end else if (sum_s < SUM_MIN) begin
            acc_new_s = ACC_MIN;
            sat_s     = 1'b1;
        end else begin
            acc_new_s = sum_s[DATA_WIDTH-1:0];
            sat_s     = 1'b0;
        end
    end

    // Accumulator register file: zeroed by reset or clear, written from S3.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ACC_DEPTH; i++) begin
                acc_r[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < ACC_DEPTH; i++) begin
                acc_r[i] <= '0;
            end
        end else if (s3_valid) begin
            acc_r[s3_addr] <= acc_new_s;
        end
    end

    // Sticky overflow: set on any clamped write, held until clear or reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (clear) begin
            ovf_r <= 1'b0;
        end else if (s3_valid && sat_s) begin
            ovf_r <= 1'b1;
        end
    end

    // Read port with write-first bypass when S3 targets the same entry.
    always_comb begin
        if (s3_valid && (s3_addr == rd_addr)) begin
            rd_value = acc_new_s;
        end else begin
            rd_value = acc_r[rd_addr];
        end
    end

    assign ovf = ovf_r;

endmodule

// File: rtl/pe_mac_lane_array.sv
// -----------------------------------------------------------------------------
// pe_mac_lane_array
// Fans one input activation out to NUM_LANES weight lanes; each lane performs
// a 3-stage signed fixed-point multiply-accumulate with saturation into its
// own accumulator file. Top level holds the handshake, stage valids, clear
// handling and the registered read port.
//
// Optional build macro: PE_MAC_RELU_EN -- when defined, rd_data lanes are
// rectified (negatives read as 0); accumulators keep signed values.
//
// Ports:
//   clk, rst (sync active-low), clear (zero accumulators/flags, flush pipe)
//   in_valid/in_ready, in_act, in_w (lane i at [i*DW +: DW]), in_addr
//   busy     : any pipeline stage valid
//   rd_en, rd_addr -> rd_valid, rd_data one cycle later (same lane packing)
//   ovf      : sticky per-lane saturation flags
// -----------------------------------------------------------------------------
module pe_mac_lane_array
    import pe_mac_pkg::*;
#(
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
    parameter int ACC_DEPTH  = DEF_ACC_DEPTH,
    parameter int ADDR_WIDTH = $clog2(ACC_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_act,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_w,
    input  logic [ADDR_WIDTH-1:0]           in_addr,
    output logic                            busy,
    input  logic                            rd_en,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    output logic                            rd_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_LANES-1:0]            ovf
);

    logic                            accept_s;
    logic                            s1_valid_r;
    logic                            s2_valid_r;
    logic                            s3_valid_r;
    logic [DATA_WIDTH-1:0]           act_r;
    logic [NUM_LANES*DATA_WIDTH-1:0] w_r;
    logic [ADDR_WIDTH-1:0]           s1_addr_r;
    logic [ADDR_WIDTH-1:0]           s2_addr_r;
    logic [ADDR_WIDTH-1:0]           s3_addr_r;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_rd_s;
    logic [NUM_LANES*DATA_WIDTH-1:0] rd_next_s;
    logic [NUM_LANES*DATA_WIDTH-1:0] rd_data_r;
    logic                            rd_valid_r;
    logic [NUM_LANES-1:0]            ovf_s;

    // No backpressure other than reset and clear.
    assign in_ready = rst & ~clear;
    assign accept_s = in_valid & in_ready;
    assign busy     = s1_valid_r | s2_valid_r | s3_valid_r;

    // Stage valids; clear flushes in-flight ops so they are never written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;
        end else if (clear) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            s3_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            s2_valid_r <= s1_valid_r;
            s3_valid_r <= s2_valid_r;
        end
    end

    // S1 operand capture plus the address that travels alongside the data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            act_r     <= '0;
            w_r       <= '0;
            s1_addr_r <= '0;
            s2_addr_r <= '0;
            s3_addr_r <= '0;
        end else begin
            if (accept_s) begin
                act_r     <= in_act;
                w_r       <= in_w;
                s1_addr_r <= in_addr;
            end
            s2_addr_r <= s1_addr_r;
            s3_addr_r <= s2_addr_r;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pe_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_WIDTH (FRAC_WIDTH),
            .ACC_DEPTH  (ACC_DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .s1_valid (s1_valid_r),
            .s2_valid (s2_valid_r),
            .s3_valid (s3_valid_r),
            .act      (act_r),
            .w        (w_r[lane_lo_f(i, DATA_WIDTH) +: DATA_WIDTH]),
            .s3_addr  (s3_addr_r),
            .rd_addr  (rd_addr),
            .rd_value (lane_rd_s[lane_lo_f(i, DATA_WIDTH) +: DATA_WIDTH]),
            .ovf      (ovf_s[i])
        );
    end

    // Read data selection: a read coinciding with clear returns zero.
    always_comb begin
        rd_next_s = '0;
        if (clear) begin
            rd_next_s = '0;
        end else begin
`ifdef PE_MAC_RELU_EN
            for (int i = 0; i < NUM_LANES; i++) begin
                rd_next_s[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(relu_f(
                    64'(lane_rd_s[i*DATA_WIDTH +: DATA_WIDTH]), DATA_WIDTH));
            end
`else
            rd_next_s = lane_rd_s;
`endif
        end
    end

    // Registered read port; rd_data holds its last value between reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                rd_data_r <= rd_next_s;
            end
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign ovf      = ovf_s;

    pe_mac_chk #(
        .ACC_DEPTH  (ACC_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .in_fire (accept_s),
        .in_addr (in_addr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr)
    );

endmodule

// File: tb/tb_pe_mac_lane_array.sv
// -----------------------------------------------------------------------------
// tb_pe_mac_lane_array
// Directed bench for pe_mac_lane_array (4 lanes, Q8.8). Reads push their
// hand-computed expected data and due cycle into a scoreboard queue; a monitor
// on the falling edge pops and compares whenever rd_valid is seen.
// -----------------------------------------------------------------------------
module tb_pe_mac_lane_array;

    localparam int NL = 4;
    localparam int DW = 16;
    localparam int AW = 6;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              clear    = 1'b0;
    logic              in_valid = 1'b0;
    logic [DW-1:0]     in_act   = '0;
    logic [NL*DW-1:0]  in_w     = '0;
    logic [AW-1:0]     in_addr  = '0;
    logic              rd_en    = 1'b0;
    logic [AW-1:0]     rd_addr  = '0;
    logic              in_ready;
    logic              busy;
    logic              rd_valid;
    logic [NL*DW-1:0]  rd_data;
    logic [NL-1:0]     ovf;

    pe_mac_lane_array #(
        .NUM_LANES  (NL),
        .DATA_WIDTH (DW),
        .FRAC_WIDTH (8),
        .ACC_DEPTH  (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_act   (in_act),
        .in_w     (in_w),
        .in_addr  (in_addr),
        .busy     (busy),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [63:0] pk(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3);
        pk = {l3, l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [15:0] a, input logic [63:0] w, input logic [AW-1:0] ad);
        in_valid = 1'b1;
        in_act   = a;
        in_w     = w;
        in_addr  = ad;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_rd(input logic [63:0] want);
        exp_t e;
        e.data = want;
        e.due  = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic rd(input logic [AW-1:0] ad, input logic [63:0] want);
        expect_rd(want);
        rd_en   = 1'b1;
        rd_addr = ad;
        step();
        rd_en = 1'b0;
        step();
    endtask

    // Scoreboard monitor: pop and compare whenever the DUT presents read data.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("rd_valid_unexpected", {63'd0, rd_valid}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rd_data", rd_data, mon_e.data);
                chk("rd_latency", 64'(cyc), 64'(mon_e.due));
            end
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            chk("rd_valid_missing", {63'd0, rd_valid}, 64'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step();
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_ovf", {60'd0, ovf}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        #1;
        chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);
        step();

        // Basic MAC, plus busy timing: low exactly three edges after accept
        op(16'h0200, pk(16'h0180, 16'h0100, 16'hFF00, 16'h0000), 6'd5);
        step();
        step();
        chk("basic_busy_s3", {63'd0, busy}, 64'd1);
        step();
        chk("basic_busy_drained", {63'd0, busy}, 64'd0);
        rd(6'd5, pk(16'h0300, 16'h0200, 16'hFE00, 16'h0000));
        chk("rd_hold", rd_data, pk(16'h0300, 16'h0200, 16'hFE00, 16'h0000));

        // Back-to-back accumulate to one address
        in_valid = 1'b1;
        in_act   = 16'h0100;
        in_w     = pk(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        in_addr  = 6'd3;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        step();
        step();
        chk("b2b_busy_s3", {63'd0, busy}, 64'd1);
        step();
        chk("b2b_busy_drained", {63'd0, busy}, 64'd0);
        rd(6'd3, pk(16'h0400, 16'h0400, 16'h0400, 16'h0400));

        // Read/write collision: read in the cycle where S3 writes addr 7
        op(16'h0100, pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 6'd7);
        step();
        step();
        rd(6'd7, pk(16'h0100, 16'h0200, 16'h0300, 16'h0400));
        rd(6'd7, pk(16'h0100, 16'h0200, 16'h0300, 16'h0400));

        // Truncation toward -inf and signed read-out (ReLU in the macro build)
        op(16'h0080, pk(16'hFD00, 16'h0500, 16'hFFFF, 16'h0001), 6'd9);
        step();
        step();
        step();
`ifdef PE_MAC_RELU_EN
        rd(6'd9, pk(16'h0000, 16'h0280, 16'h0000, 16'h0000));
`else
        rd(6'd9, pk(16'hFE80, 16'h0280, 16'hFFFF, 16'h0000));
`endif
        chk("no_ovf_yet", {60'd0, ovf}, 64'd0);

        // Saturation on lanes 0 (positive) and 1 (negative)
        in_valid = 1'b1;
        in_act   = 16'h7FFF;
        in_w     = pk(16'h7FFF, 16'h8001, 16'h0000, 16'h0000);
        in_addr  = 6'd0;
        for (int i = 0; i < 200; i++) step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("sat_busy_drained", {63'd0, busy}, 64'd0);
        rd(6'd0, pk(16'h7FFF, 16'h8000, 16'h0000, 16'h0000));
        chk("sat_ovf", {60'd0, ovf}, 64'd3);

        // Clear mid-flight, with a concurrent read and a presented operand
        op(16'h0100, pk(16'h0100, 16'h0100, 16'h0100, 16'h0100), 6'd12);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_addr  = 6'd13;
        rd_en    = 1'b1;
        rd_addr  = 6'd5;
        expect_rd(64'd0);
        #1;
        chk("clear_in_ready", {63'd0, in_ready}, 64'd0);
        chk("clear_busy_inflight", {63'd0, busy}, 64'd1);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        chk("clear_busy_flushed", {63'd0, busy}, 64'd0);
        chk("clear_ovf", {60'd0, ovf}, 64'd0);
        step();
        step();
        step();
        rd(6'd12, 64'd0);
        rd(6'd13, 64'd0);
        rd(6'd0, 64'd0);
        rd(6'd3, 64'd0);

        // Reset with three ops in flight
        op(16'h0100, pk(16'h0100, 16'h0100, 16'h0100, 16'h0100), 6'd21);
        step();
        step();
        step();
        rd(6'd21, pk(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        in_valid = 1'b1;
        in_addr  = 6'd20;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        chk("rst_mid_busy_before", {63'd0, busy}, 64'd1);
        rst     = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 6'd21;
        step();
        rd_en = 1'b0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_mid_rd_data", rd_data, 64'd0);
        chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("rst_hold_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        step();
        step();
        step();
        step();
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        rd(6'd20, 64'd0);
        rd(6'd21, 64'd0);

        step();
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
